// File: rtl/l2_noc2_arb_pkg.sv
// Shared types and constants for the L2 NoC2 output arbiter and its flit serializer.
package l2_noc2_arb_pkg;

    localparam int FLIT_W    = 64;
    localparam int MAX_FLITS = 3;
    localparam int MSG_W     = FLIT_W * MAX_FLITS;

    typedef logic [1:0] msg_len_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_SEND = 1'b1
    } arb_state_e;

    // A zero-length message is illegal; treat it as a single flit.
    function automatic msg_len_t clamp_len(input msg_len_t len);
        return (len == 2'd0) ? 2'd1 : len;
    endfunction

endpackage

// File: rtl/l2_noc2_flit_ser.sv
// Message buffer and flit serializer: loads a whole message, steps the flit index on each
// downstream handshake and flags the last flit.
module l2_noc2_flit_ser #(
    parameter int FLIT_W    = l2_noc2_arb_pkg::FLIT_W,
    parameter int MAX_FLITS = l2_noc2_arb_pkg::MAX_FLITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_i,
    input  logic [1:0]                    len_i,
    input  logic [FLIT_W*MAX_FLITS-1:0]   data_i,
    input  logic                          adv_i,
    output logic [FLIT_W-1:0]             flit_o,
    output logic                          last_o
);
    import l2_noc2_arb_pkg::*;

    logic [FLIT_W*MAX_FLITS-1:0] buf_q, buf_d;
    msg_len_t                    len_q, len_d;
    logic [1:0]                  idx_q, idx_d;

    assign last_o = (idx_q == (len_q - 2'd1));
    assign flit_o = buf_q[int'(idx_q) * FLIT_W +: FLIT_W];

    // Next-state: a load restarts at flit 0; the index wraps to 0 after the last flit.
    always_comb begin
        buf_d = buf_q;
        len_d = len_q;
        idx_d = idx_q;
        if (load_i) begin
            buf_d = data_i;
            len_d = clamp_len(len_i);
            idx_d = 2'd0;
        end else if (adv_i) begin
            idx_d = last_o ? 2'd0 : (idx_q + 2'd1);
        end else begin
            idx_d = idx_q;
        end
    end

    // Buffer, length and index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
            len_q <= 2'd0;
            idx_q <= 2'd0;
        end else begin
            buf_q <= buf_d;
            len_q <= len_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/l2_noc2_out_arb.sv
// NoC2 output arbiter: grants one whole pipe1/pipe2 message at a time and streams its flits.
// Optional pipe1 anti-starvation is enabled by defining L2_NOC2_ARB_FAIR_EN.
module l2_noc2_out_arb #(
    parameter int FLIT_W       = l2_noc2_arb_pkg::FLIT_W,
    parameter int MAX_FLITS    = l2_noc2_arb_pkg::MAX_FLITS,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          p1_msg_valid,
    output logic                          p1_msg_ready,
    input  logic [1:0]                    p1_msg_len,
    input  logic [FLIT_W*MAX_FLITS-1:0]   p1_msg_data,
    input  logic                          p2_msg_valid,
    output logic                          p2_msg_ready,
    input  logic [1:0]                    p2_msg_len,
    input  logic [FLIT_W*MAX_FLITS-1:0]   p2_msg_data,
    output logic                          noc2_valid_out,
    input  logic                          noc2_ready_out,
    output logic [FLIT_W-1:0]             noc2_data_out,
    output logic                          grant_p2,
    output logic                          busy
);
    import l2_noc2_arb_pkg::*;

    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

    arb_state_e              state_q, state_d;
    logic                    grant_q, grant_d;
    logic                    send_s, xfer_s, last_xfer_s, can_accept_s;
    logic                    force_p1_s, p1_win_s, p2_win_s, accept_s;
    logic                    ser_last_s;
    logic [FLIT_W-1:0]       ser_flit_s;
    logic [1:0]              load_len_s;
    logic [FLIT_W*MAX_FLITS-1:0] load_data_s;

    assign send_s       = (state_q == ARB_SEND);
    assign xfer_s       = send_s & noc2_ready_out;
    assign last_xfer_s  = xfer_s & ser_last_s;
    assign can_accept_s = ~send_s | last_xfer_s;

    // Pipe2 (responses) wins by default; pipe1 wins when pipe2 is idle or when forced.
    assign p1_win_s     = p1_msg_valid & (~p2_msg_valid | force_p1_s);
    assign p2_win_s     = p2_msg_valid & ~p1_win_s;
    assign p1_msg_ready = can_accept_s & p1_win_s;
    assign p2_msg_ready = can_accept_s & p2_win_s;
    assign accept_s     = p1_msg_ready | p2_msg_ready;

    assign load_len_s   = p2_msg_ready ? p2_msg_len  : p1_msg_len;
    assign load_data_s  = p2_msg_ready ? p2_msg_data : p1_msg_data;

`ifdef L2_NOC2_ARB_FAIR_EN
    logic [2:0] starve_q, starve_d;

    assign force_p1_s = p1_msg_valid & (starve_q == STARVE_MAX);

    // Count pipe1 losses at acceptance time; any pipe1 grant clears the count.
    always_comb begin
        starve_d = starve_q;
        if (p1_msg_ready) begin
            starve_d = 3'd0;
        end else if (p2_msg_ready & p1_msg_valid & (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 3'd1;
        end else begin
            starve_d = starve_q;
        end
    end

    // Starve counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= 3'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_p1_s = 1'b0 & (STARVE_MAX != 3'd0);
`endif

    // Arbiter FSM next state and grant owner.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        if (accept_s) begin
            state_d = ARB_SEND;
            grant_d = p2_msg_ready;
        end else if (last_xfer_s) begin
            state_d = ARB_IDLE;
            grant_d = 1'b0;
        end else begin
            state_d = state_q;
            grant_d = grant_q;
        end
    end

    // FSM state and grant registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    l2_noc2_flit_ser #(
        .FLIT_W    (FLIT_W),
        .MAX_FLITS (MAX_FLITS)
    ) u_ser (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept_s),
        .len_i  (load_len_s),
        .data_i (load_data_s),
        .adv_i  (xfer_s),
        .flit_o (ser_flit_s),
        .last_o (ser_last_s)
    );

    assign noc2_valid_out = send_s;
    assign noc2_data_out  = send_s ? ser_flit_s : {FLIT_W{1'b0}};
    assign grant_p2       = grant_q;
    assign busy           = send_s;

endmodule

// File: tb/tb_l2_noc2_out_arb.sv
// Self-checking bench for l2_noc2_out_arb: scoreboard of expected flits plus directed timing checks.
module tb_l2_noc2_out_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic         p1_msg_valid, p1_msg_ready, p2_msg_valid, p2_msg_ready;
    logic [1:0]   p1_msg_len, p2_msg_len;
    logic [191:0] p1_msg_data, p2_msg_data;
    logic         noc2_valid_out, noc2_ready_out, grant_p2, busy;
    logic [63:0]  noc2_data_out;

    typedef struct {
        logic [63:0] data;
        logic        g2;
    } exp_t;

    exp_t sb[$];
    int   acc_log[$];
    int   compared   = 0;
    int   mismatched = 0;

    l2_noc2_out_arb dut (
        .clk            (clk),
        .rst            (rst),
        .p1_msg_valid   (p1_msg_valid),
        .p1_msg_ready   (p1_msg_ready),
        .p1_msg_len     (p1_msg_len),
        .p1_msg_data    (p1_msg_data),
        .p2_msg_valid   (p2_msg_valid),
        .p2_msg_ready   (p2_msg_ready),
        .p2_msg_len     (p2_msg_len),
        .p2_msg_data    (p2_msg_data),
        .noc2_valid_out (noc2_valid_out),
        .noc2_ready_out (noc2_ready_out),
        .noc2_data_out  (noc2_data_out),
        .grant_p2       (grant_p2),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [191:0] mk(input logic [15:0] id);
        return {id, 48'h0000_0000_0C03, id, 48'h0000_0000_0B02, id, 48'h0000_0000_0A01};
    endfunction

    function automatic logic [63:0] flit_of(input logic [191:0] d, input int k);
        return d[k*64 +: 64];
    endfunction

    // Present one message on a pipe (caller is just after a rising edge) until it is accepted.
    task automatic drive(input int pipe, input logic [1:0] len, input logic [191:0] data);
        int   lc;
        exp_t e;
        bit   ok = 1'b0;
        if (pipe == 1) begin
            p1_msg_valid = 1'b1; p1_msg_len = len; p1_msg_data = data;
        end else begin
            p2_msg_valid = 1'b1; p2_msg_len = len; p2_msg_data = data;
        end
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if ((pipe == 1 && p1_msg_ready) || (pipe == 2 && p2_msg_ready)) begin
                lc = (len == 2'd0) ? 1 : int'(len);
                for (int k = 0; k < lc; k++) begin
                    e.data = flit_of(data, k);
                    e.g2   = (pipe == 2);
                    sb.push_back(e);
                end
                acc_log.push_back(pipe);
                ok = 1'b1;
                @(posedge clk); #1;
                if (pipe == 1) p1_msg_valid = 1'b0; else p2_msg_valid = 1'b0;
                break;
            end
        end
        if (!ok) begin
            compared++; mismatched++;
            $display("FAIL accept_timeout pipe%0d: got no ready, required ready within 300 cycles", pipe);
            if (pipe == 1) p1_msg_valid = 1'b0; else p2_msg_valid = 1'b0;
        end
    endtask

    // Pop and compare every downstream handshake; span = cycles from first to last flit.
    task automatic monitor(input int n, input int budget, output int span);
        exp_t e;
        int   got = 0;
        int   first_c = -1;
        span = -1;
        for (int c = 0; c < budget && got < n; c++) begin
            @(negedge clk);
            if (noc2_valid_out && noc2_ready_out) begin
                if (first_c < 0) first_c = c;
                span = c - first_c;
                got++;
                compared++;
                if (sb.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_flit: got %h, required no flit", noc2_data_out);
                end else begin
                    e = sb.pop_front();
                    if (noc2_data_out !== e.data || grant_p2 !== e.g2) begin
                        mismatched++;
                        $display("FAIL flit: got data=%h g2=%b, required data=%h g2=%b",
                                 noc2_data_out, grant_p2, e.data, e.g2);
                    end
                end
            end
        end
        if (got < n) begin
            compared++; mismatched++;
            $display("FAIL flit_timeout: got %0d flits, required %0d", got, n);
        end
    endtask

    task automatic check_idle(input string name);
        compared++;
        if (busy !== 1'b0 || noc2_valid_out !== 1'b0 || noc2_data_out !== 64'h0 || grant_p2 !== 1'b0) begin
            mismatched++;
            $display("FAIL %s: got busy=%b valid=%b data=%h g2=%b, required all 0",
                     name, busy, noc2_valid_out, noc2_data_out, grant_p2);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset_outputs");
        compared++;
        if (p1_msg_ready !== 1'b0 || p2_msg_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_ready: got %b%b, required 00", p1_msg_ready, p2_msg_ready);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_p1_len3();
        logic [191:0] d;
        d = mk(16'h1111);
        p1_msg_valid = 1'b1; p1_msg_len = 2'd3; p1_msg_data = d;
        @(negedge clk);
        compared++;
        if (p1_msg_ready !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL p1_ready_cycle0: got ready=%b busy=%b, required ready=1 busy=0", p1_msg_ready, busy);
        end
        @(posedge clk); #1;
        p1_msg_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            compared++;
            if (noc2_valid_out !== 1'b1 || noc2_data_out !== flit_of(d, k) || busy !== 1'b1 || grant_p2 !== 1'b0) begin
                mismatched++;
                $display("FAIL p1_flit%0d: got v=%b data=%h busy=%b g2=%b, required v=1 data=%h busy=1 g2=0",
                         k, noc2_valid_out, noc2_data_out, busy, grant_p2, flit_of(d, k));
            end
        end
        @(negedge clk);
        check_idle("p1_done_cycle4");
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int span;
        acc_log.delete();
        fork
            drive(2, 2'd1, mk(16'h2222));
            drive(1, 2'd1, mk(16'h3333));
            monitor(2, 50, span);
        join
        compared++;
        if (acc_log.size() != 2 || acc_log[0] != 2 || acc_log[1] != 1) begin
            mismatched++;
            $display("FAIL both_valid_order: got %p, required '{2,1}", acc_log);
        end
        compared++;
        if (span != 1) begin
            mismatched++;
            $display("FAIL both_valid_gap: got span %0d cycles, required 1", span);
        end
        @(negedge clk);
        check_idle("both_valid_idle");
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [191:0] d;
        d = mk(16'h4444);
        p1_msg_valid = 1'b1; p1_msg_len = 2'd2; p1_msg_data = d;
        @(posedge clk); #1;
        p1_msg_valid = 1'b0;
        @(negedge clk);
        compared++;
        if (noc2_valid_out !== 1'b1 || noc2_data_out !== flit_of(d, 0)) begin
            mismatched++;
            $display("FAIL bp_flit0: got v=%b data=%h, required v=1 data=%h", noc2_valid_out, noc2_data_out, flit_of(d, 0));
        end
        @(posedge clk); #1;
        noc2_ready_out = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            compared++;
            if (noc2_valid_out !== 1'b1 || noc2_data_out !== flit_of(d, 1)) begin
                mismatched++;
                $display("FAIL bp_hold%0d: got v=%b data=%h, required v=1 data=%h",
                         i, noc2_valid_out, noc2_data_out, flit_of(d, 1));
            end
            @(posedge clk); #1;
        end
        noc2_ready_out = 1'b1;
        @(negedge clk);
        compared++;
        if (noc2_valid_out !== 1'b1 || noc2_data_out !== flit_of(d, 1)) begin
            mismatched++;
            $display("FAIL bp_release: got v=%b data=%h, required v=1 data=%h", noc2_valid_out, noc2_data_out, flit_of(d, 1));
        end
        @(negedge clk);
        check_idle("bp_done");
        @(posedge clk); #1;
    endtask

    task automatic test_fairness();
        int span;
        int exp_order[$];
`ifdef L2_NOC2_ARB_FAIR_EN
        exp_order = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1, 2, 2};
`else
        exp_order = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 1, 1};
`endif
        acc_log.delete();
        fork
            begin
                for (int i = 0; i < 10; i++) drive(2, 2'd1, mk(16'h5000 + 16'(i)));
            end
            begin
                for (int i = 0; i < 2; i++) drive(1, 2'd1, mk(16'h6000 + 16'(i)));
            end
            monitor(12, 400, span);
        join
        compared++;
        if (acc_log != exp_order) begin
            mismatched++;
            $display("FAIL grant_order: got %p, required %p", acc_log, exp_order);
        end
        compared++;
        if (span != 11) begin
            mismatched++;
            $display("FAIL grant_stream_gap: got span %0d, required 11", span);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [191:0] d;
        int span;
        d = mk(16'h7777);
        p2_msg_valid = 1'b1; p2_msg_len = 2'd3; p2_msg_data = d;
        @(posedge clk); #1;
        p2_msg_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        compared++;
        if (noc2_data_out !== flit_of(d, 1) || grant_p2 !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_flit1: got data=%h g2=%b, required data=%h g2=1", noc2_data_out, grant_p2, flit_of(d, 1));
        end
        #2 rst = 1'b1;
        #1;
        check_idle("async_reset_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        fork
            drive(1, 2'd2, mk(16'h8888));
            monitor(2, 50, span);
        join
        @(negedge clk);
        check_idle("after_reset_msg");
        @(posedge clk); #1;
    endtask

    task automatic test_len0();
        int span;
        fork
            drive(2, 2'd0, mk(16'h9999));
            monitor(1, 50, span);
        join
        @(negedge clk);
        check_idle("len0_idle");
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL len0_leftover: got %0d pending flits, required 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        p1_msg_valid = 1'b0; p1_msg_len = 2'd0; p1_msg_data = '0;
        p2_msg_valid = 1'b0; p2_msg_len = 2'd0; p2_msg_data = '0;
        noc2_ready_out = 1'b1;
        test_reset();
        test_single_p1_len3();
        test_back_to_back();
        test_backpressure();
        test_fairness();
        test_reset_mid();
        test_len0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/l2_noc2_out_arb.md
# l2_noc2_out_arb

Output arbiter and serializer for the L2 NoC2 port. It shares the single 64-bit `noc2` output between the pipe1 and pipe2 message generators. It accepts one whole message (1–3 flits) per grant and streams its flits onto `noc2_data_out` under the valid/ready handshake. It sits between the two pipeline message-send stages and the L2 top-level `noc2_*_out` ports.

## Interface
Parameters:
- `FLIT_W`, 64: NoC flit width.
- `MAX_FLITS`, 3: maximum flits per message.
- `STARVE_LIMIT`, 4: pipe1 losses before a forced pipe1 grant (used only with the fairness feature).

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `p1_msg_valid`  in  1  pipe1 has a message.
- `p1_msg_ready`  out  1  pipe1 message accepted this cycle.
- `p1_msg_len`  in  2  pipe1 flit count, 1..3.
- `p1_msg_data`  in  192  pipe1 flits; flit k is `[64k+63:64k]`.
- `p2_msg_valid`, `p2_msg_ready`, `p2_msg_len`, `p2_msg_data`: the same four signals for pipe2.
- `noc2_valid_out`  out  1  flit valid.
- `noc2_ready_out`  in  1  downstream ready.
- `noc2_data_out`  out  64  current flit.
- `grant_p2`  out  1  message in flight is from pipe2; 0 when idle.
- `busy`  out  1  a message is in flight.

## Operation
FSM states:
- **IDLE**
  - Accept condition: `can_accept = (state==IDLE) | last_flit_xfer`, where `last_flit_xfer = noc2_valid_out & noc2_ready_out & (idx==len-1)`.
  - Winner when `can_accept`: pipe2 by default (responses unblock pipe1). Pipe1 wins when pipe2 is not valid, or when a forced grant applies (see Configuration).
- **Acceptance**
  - Exactly one `pX_msg_ready` is asserted, combinationally, for the winner only while `can_accept`.
  - On `valid & ready`: capture data into a 192-bit buffer, capture len, clear `idx`, set `grant_p2`, go to SEND.
  - `len==0` is illegal and is clamped to 1.
- **SEND**
  - `noc2_valid_out=1`, `noc2_data_out=buf[idx]`.
  - On handshake: `idx++`.
  - On `last_flit_xfer`: accept the next winner in the same cycle if one is valid, giving back-to-back messages. Otherwise go to IDLE.
- **Requester rules:** `valid`, `len` and `data` are held stable until ready. The block does not require this for correctness, because it samples only at acceptance.
- **Output values:**
  - `noc2_data_out` is 0 in IDLE.
  - `busy = (state==SEND)`.
  - `grant_p2` is 0 in IDLE.
- **Reset:** asynchronous, at any time, including mid-message. Required results:
  - FSM to IDLE, `idx=0`, buffer and len cleared, starve counter 0.
  - The partial message is dropped.
  - All outputs 0.

## Timing
- `pX_msg_ready` is combinational from `pX_msg_valid`, state and the NoC handshake; no registered bubble.
- Flit 0 appears on `noc2_data_out` the cycle after acceptance.
- An n-flit message occupies exactly n cycles with `noc2_ready_out` held high.
- Back-to-back messages run with zero idle cycles.
- `noc2_ready_out` low holds flit, `idx` and `noc2_valid_out` unchanged. `valid` never drops before its handshake.
- Simultaneous valid from both pipes: one grant only. The loser sees ready=0 and holds.

## Configuration
- **Macro `L2_NOC2_ARB_FAIR_EN` defined:**
  - A 3-bit starve counter increments, saturating at `STARVE_LIMIT`, on each acceptance where pipe1 was valid and pipe2 won.
  - It clears when pipe1 is accepted.
  - When the counter equals `STARVE_LIMIT` and pipe1 is valid, pipe1 wins over pipe2.
- **Macro undefined:** strict pipe2 priority. No counter logic is compiled.

## Structure
- **Package `l2_noc2_arb_pkg`:**
  - State enum `{ARB_IDLE, ARB_SEND}`.
  - `FLIT_W`, `MAX_FLITS`, `MSG_W = FLIT_W*MAX_FLITS`.
  - `msg_len_t` (2 bits).
- **Sub-module `l2_noc2_flit_ser`:**
  - Holds buffer, len and idx.
  - Implements the load/shift/last-flit logic.
  - The top holds the arbitration and the starve counter.

## Test plan
- Pipe1 only, len=3, flits A/B/C, `noc2_ready_out`=1:
  - `p1_msg_ready` pulses in cycle 0.
  - `noc2_data_out` shows A, B, C in cycles 1–3.
  - `busy` falls in cycle 4.
- Both pipes valid in the same cycle, len=1 each: pipe2 flit goes out first, pipe1 is accepted on the last-flit cycle, and its flit follows with no gap.
- `noc2_ready_out` low for 5 cycles mid-message (len=2): flit 1 is held stable and `idx` does not advance; completion happens one cycle after ready returns.
- With `L2_NOC2_ARB_FAIR_EN`, pipe1 and pipe2 continuously valid, `STARVE_LIMIT`=4: grant order P2 P2 P2 P2 P1 P2… repeating. Without the macro, pipe1 is never granted.
- `rst` pulsed during flit 1 of a 3-flit message: all outputs are 0 immediately, and the next accepted message starts at flit 0.
- `len=0` from pipe2: exactly one flit is sent, then IDLE.
